// File: rtl/proc_wait_ctrl.sv
// Wait-command sequencer: runs relative/external timed waits, event waits, reports illegal commands.
// Latency: accept at edge T -> WAIT/EVENT/DONE from T+1; timed wait of N lasts N cycles, DONE at T+N+1.
// Backpressure: cmd_ready is high only in IDLE, so an accepted command blocks the next until DONE/abort.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   cmd_valid      command present
//   cmd_ready      block idle and able to take a command
//   cmd_type       1 = relative wait, 2 = external wait, 3 = event wait, others illegal
//   proc_rel_time  cycle count used by a relative wait
//   proc_ext_time  cycle count used by an external wait
//   event_hit      single-cycle strobe that ends an event wait
//   abort          cancels an active wait (WAIT or EVENT)
//   ckg_ind        clock-gate indicator, high while waiting
//   wait_done      one-cycle completion pulse
//   cmd_err        one-cycle pulse after an illegal command is taken
//   wait_cnt       current down-counter value
module proc_wait_ctrl #(
    parameter int PARA = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [4:0]      cmd_type,
    input  logic [PARA-1:0] proc_rel_time,
    input  logic [PARA-1:0] proc_ext_time,
    input  logic            event_hit,
    input  logic            abort,
    output logic            ckg_ind,
    output logic            wait_done,
    output logic            cmd_err,
    output logic [PARA-1:0] wait_cnt
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_EVENT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [4:0] TYPE_REL = 5'd1;
    localparam logic [4:0] TYPE_EXT = 5'd2;
    localparam logic [4:0] TYPE_EVT = 5'd3;

    localparam logic [PARA-1:0] CNT_ZERO = '0;
    localparam logic [PARA-1:0] CNT_ONE  = PARA'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      state_q, state_d;
    logic [PARA-1:0] cnt_q,   cnt_d;
    logic            cmd_err_q, cmd_err_d;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic            cmd_accept;
    logic            is_timed;
    logic            is_event;
    logic [PARA-1:0] sel_time;

    assign cmd_accept = cmd_valid && (state_q == ST_IDLE);
    assign is_timed   = (cmd_type == TYPE_REL) || (cmd_type == TYPE_EXT);
    assign is_event   = (cmd_type == TYPE_EVT);
    // Only meaningful when is_timed; type 1 takes the relative field, type 2 the external one.
    assign sel_time   = (cmd_type == TYPE_EXT) ? proc_ext_time : proc_rel_time;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (is_timed) begin
                        // A zero-length wait goes straight to DONE so the gate never opens.
                        if (sel_time == CNT_ZERO) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = sel_time;
                        end
                    end else if (is_event) begin
                        // Counter deliberately untouched for event waits.
                        state_d = ST_EVENT;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                // Abort wins over the final count so a cancelled wait never signals done.
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_EVENT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (event_hit) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, no input-to-output path
    // ------------------------------------------------------------------
    assign cmd_ready = (state_q == ST_IDLE);
    assign ckg_ind   = (state_q == ST_WAIT) || (state_q == ST_EVENT);
    assign wait_done = (state_q == ST_DONE);
    assign cmd_err   = cmd_err_q;
    assign wait_cnt  = cnt_q;

endmodule

// File: tb/tb_proc_wait_ctrl.sv
module tb_proc_wait_ctrl;

    localparam int PARA = 4;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [4:0]      cmd_type;
    logic [PARA-1:0] proc_rel_time;
    logic [PARA-1:0] proc_ext_time;
    logic            event_hit;
    logic            abort;
    logic            ckg_ind;
    logic            wait_done;
    logic            cmd_err;
    logic [PARA-1:0] wait_cnt;

    int checks = 0;
    int errors = 0;

    proc_wait_ctrl #(.PARA(PARA)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_type      (cmd_type),
        .proc_rel_time (proc_rel_time),
        .proc_ext_time (proc_ext_time),
        .event_hit     (event_hit),
        .abort         (abort),
        .ckg_ind       (ckg_ind),
        .wait_done     (wait_done),
        .cmd_err       (cmd_err),
        .wait_cnt      (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs: ready, gate, done, err
    task automatic chk4(input string tag, input logic rdy, input logic ckg,
                        input logic done, input logic err);
        chk({tag, ".cmd_ready"}, {7'd0, cmd_ready}, {7'd0, rdy});
        chk({tag, ".ckg_ind"},   {7'd0, ckg_ind},   {7'd0, ckg});
        chk({tag, ".wait_done"}, {7'd0, wait_done}, {7'd0, done});
        chk({tag, ".cmd_err"},   {7'd0, cmd_err},   {7'd0, err});
    endtask

    task automatic chk_cnt(input string tag, input logic [PARA-1:0] exp);
        chk({tag, ".wait_cnt"}, {4'd0, wait_cnt}, {4'd0, exp});
    endtask

    // Advance one clock; sampling point is 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a command and let it be taken at the next edge; returns in cycle T+1.
    task automatic send(input logic [4:0] t, input logic [PARA-1:0] rel, input logic [PARA-1:0] ext);
        cmd_valid     = 1'b1;
        cmd_type      = t;
        proc_rel_time = rel;
        proc_ext_time = ext;
        cyc();
        cmd_valid     = 1'b0;
    endtask

    initial begin
        int n_wait;
        bit seen_done;

        rst = 1'b0; cmd_valid = 1'b0; cmd_type = 5'd0;
        proc_rel_time = '0; proc_ext_time = '0; event_hit = 1'b0; abort = 1'b0;

        // Reset state
        repeat (2) cyc();
        chk4("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 4'd0);
        rst = 1'b1;

        // Relative wait of 3, accepted on first edge after reset release
        send(5'd1, 4'd3, 4'd9);
        chk4("rel3_t1", 1'b0, 1'b1, 1'b0, 1'b0); chk_cnt("rel3_t1", 4'd3);
        cyc(); chk4("rel3_t2", 1'b0, 1'b1, 1'b0, 1'b0); chk_cnt("rel3_t2", 4'd2);
        cyc(); chk4("rel3_t3", 1'b0, 1'b1, 1'b0, 1'b0); chk_cnt("rel3_t3", 4'd1);
        cyc(); chk4("rel3_t4", 1'b0, 1'b0, 1'b1, 1'b0); chk_cnt("rel3_t4", 4'd1);
        cyc(); chk4("rel3_t5", 1'b1, 1'b0, 1'b0, 1'b0);

        // External wait of 0: straight to DONE, gate never opens
        send(5'd2, 4'd5, 4'd0);
        chk4("ext0_t1", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(); chk4("ext0_t2", 1'b1, 1'b0, 1'b0, 1'b0);

        // External wait of 15 (max load): exactly 15 gated cycles, no wrap
        send(5'd2, 4'd3, 4'd15);
        chk_cnt("ext15_t1", 4'd15);
        n_wait = 0; seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ckg_ind) n_wait++;
            if (wait_done) begin
                seen_done = 1'b1;
                break;
            end
            cyc();
        end
        chk("ext15_done_seen", {7'd0, seen_done}, 8'd1);
        chk("ext15_wait_cycles", n_wait[7:0], 8'd15);
        cyc(); chk4("ext15_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // event_hit in IDLE is ignored
        event_hit = 1'b1;
        cyc(); event_hit = 1'b0;
        chk4("evt_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Event wait, event_hit during T+5; counter left at 1
        send(5'd3, 4'd7, 4'd7);
        chk4("evt_t1", 1'b0, 1'b1, 1'b0, 1'b0); chk_cnt("evt_t1", 4'd1);
        cyc(); cyc(); cyc();
        chk4("evt_t4", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk4("evt_t5", 1'b0, 1'b1, 1'b0, 1'b0);
        event_hit = 1'b1;
        cyc(); event_hit = 1'b0;
        chk4("evt_t6", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(); chk4("evt_t7", 1'b1, 1'b0, 1'b0, 1'b0);

        // Relative wait of 4, abort in the counter==1 cycle
        send(5'd1, 4'd4, 4'd0);
        cyc(); cyc(); cyc();
        chk4("abrt_t4", 1'b0, 1'b1, 1'b0, 1'b0); chk_cnt("abrt_t4", 4'd1);
        abort = 1'b1;
        cyc(); abort = 1'b0;
        chk4("abrt_t5", 1'b1, 1'b0, 1'b0, 1'b0); chk_cnt("abrt_t5", 4'd0);
        cyc(); chk4("abrt_t6", 1'b1, 1'b0, 1'b0, 1'b0);

        // abort in IDLE ignored: command still taken
        abort = 1'b1;
        send(5'd1, 4'd2, 4'd0);
        abort = 1'b0;
        chk4("abrt_idle_t1", 1'b0, 1'b1, 1'b0, 1'b0); chk_cnt("abrt_idle_t1", 4'd2);
        cyc(); cyc();
        chk4("abrt_idle_t3", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();

        // abort together with event_hit in EVENT: abort wins
        send(5'd3, 4'd0, 4'd0);
        cyc();
        abort = 1'b1; event_hit = 1'b1;
        cyc(); abort = 1'b0; event_hit = 1'b0;
        chk4("abrt_evt", 1'b1, 1'b0, 1'b0, 1'b0); chk_cnt("abrt_evt", 4'd0);
        cyc(); chk4("abrt_evt_next", 1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal type 7: one-cycle error, still ready
        send(5'd7, 4'd3, 4'd3);
        chk4("ill_t1", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(); chk4("ill_t2", 1'b1, 1'b0, 1'b0, 1'b0);

        // Async reset mid-WAIT with counter 2
        send(5'd1, 4'd5, 4'd0);
        cyc(); cyc(); cyc();
        chk_cnt("rst_pre", 4'd2);
        #2 rst = 1'b0;
        #1;
        chk4("rst_async", 1'b1, 1'b0, 1'b0, 1'b0); chk_cnt("rst_async", 4'd0);
        #2 rst = 1'b1;
        send(5'd1, 4'd1, 4'd0);
        chk4("post_rst_t1", 1'b0, 1'b1, 1'b0, 1'b0); chk_cnt("post_rst_t1", 4'd1);
        cyc(); chk4("post_rst_t2", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(); chk4("post_rst_t3", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
